// File: rtl/eluks_pkg.sv
// rtl/eluks_pkg.sv - shared types and helpers for the ELUKS block streamer
// Purpose: state encodings for the streamer FSM and the request handshake,
//          plus the bytes-per-word helper used to size the packer.
// Ports:   none (package).
package eluks_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    BYTE,
    PUSH,
    NEXT,
    DONE,
    ERR
  } stream_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_WAIT
  } hs_state_t;

  function automatic int bytes_per_word(input int out_width);
    return out_width / 8;
  endfunction

endpackage

// File: rtl/eluks_req_hs.sv
// rtl/eluks_req_hs.sv - request/busy handshake with per-request timeout
// Purpose: raises r_block or r_byte (chosen by kind_i) while go_i is high,
//          holds it until the core shows busy, then waits for busy to fall.
// Ports:   clk_i, rst_ni    clock, synchronous active-low reset
//          go_i             owner state wants a request; low aborts
//          kind_i           0 = sector open (r_block), 1 = byte read (r_byte)
//          core_busy_i      core busy
//          r_block_o        sector-open request level
//          r_byte_o         byte request level
//          cmpl_o           1-cycle completion strobe (busy seen falling)
//          timeout_o        request has been outstanding TIMEOUT_CYCLES cycles
module eluks_req_hs
  import eluks_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic go_i,
  input  logic kind_i,
  input  logic core_busy_i,
  output logic r_block_o,
  output logic r_byte_o,
  output logic cmpl_o,
  output logic timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  hs_state_t     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HS_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    cmpl_o  = 1'b0;
    case (state_q)
      HS_IDLE: if (go_i) state_d = HS_REQ;
      HS_REQ: begin
        tmr_d = tmr_q + 1'b1;
        if (core_busy_i) state_d = HS_WAIT;
      end
      HS_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (!core_busy_i) begin
          cmpl_o  = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
    // Owner left OPEN/BYTE (error or reset path): abandon the request.
    if (!go_i) begin
      state_d = HS_IDLE;
      tmr_d   = '0;
      cmpl_o  = 1'b0;
    end
  end

  // Gated by go_i so requests drop in the same cycle the owner enters ERR.
  assign r_block_o = go_i && (state_q == HS_REQ) && !kind_i;
  assign r_byte_o  = go_i && (state_q == HS_REQ) && kind_i;
  assign timeout_o = go_i && (state_q != HS_IDLE) && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/eluks_block_streamer.sv
// rtl/eluks_block_streamer.sv - streams decrypted sectors as packed words
// Purpose: reads n_blocks consecutive sectors byte by byte from the decrypt
//          core and packs them little-endian into OUT_WIDTH-bit stream words.
// Ports:   wb_clk, wb_rst_n           clock, synchronous active-low reset
//          start, first_addr, n_blocks run request (sampled in IDLE)
//          busy, done, err            run status (err is sticky)
//          core_addr, core_r_block, core_r_byte, core_busy, core_data,
//          core_error                 decrypt core byte-read port
//          out_tdata, out_tvalid, out_tready, out_tlast  output word stream
module eluks_block_streamer
  import eluks_pkg::*;
#(
  parameter int BLOCK_BYTES    = 512,
  parameter int OUT_WIDTH      = 32,
  parameter int NBLK_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  start,
  input  logic [31:0]           first_addr,
  input  logic [NBLK_WIDTH-1:0] n_blocks,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           core_addr,
  output logic                  core_r_block,
  output logic                  core_r_byte,
  input  logic                  core_busy,
  input  logic [7:0]            core_data,
  input  logic                  core_error,
  output logic [OUT_WIDTH-1:0]  out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast
);

  localparam int BPW = bytes_per_word(OUT_WIDTH);
  localparam int BCW = $clog2(BLOCK_BYTES) + 1;
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

  stream_state_t         state_q, state_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [NBLK_WIDTH-1:0] blk_cnt_q, blk_cnt_d;
  logic [NBLK_WIDTH-1:0] nblk_q, nblk_d;
  logic [31:0]           addr_q, addr_d;
  logic [OUT_WIDTH-1:0]  word_q, word_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  hs_go, hs_kind, hs_cmpl, hs_timeout;
  logic                  err_evt, sector_end, word_full;
  logic [LW-1:0]         lane;

  eluks_req_hs #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_req_hs (
    .clk_i      (wb_clk),
    .rst_ni     (wb_rst_n),
    .go_i       (hs_go),
    .kind_i     (hs_kind),
    .core_busy_i(core_busy),
    .r_block_o  (core_r_block),
    .r_byte_o   (core_r_byte),
    .cmpl_o     (hs_cmpl),
    .timeout_o  (hs_timeout)
  );

  assign hs_go      = (state_q == OPEN) || (state_q == BYTE);
  assign hs_kind    = (state_q == BYTE);
  // ERR itself does not resample errors so a held core_error cannot pin the FSM there.
  assign err_evt    = (state_q != IDLE) && (state_q != ERR) && (core_error || hs_timeout);
  assign lane       = LW'(byte_cnt_q) & LW'(BPW - 1);
  assign word_full  = (lane == LW'(BPW - 1));
  assign sector_end = (byte_cnt_q == BCW'(BLOCK_BYTES));

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      blk_cnt_q  <= '0;
      nblk_q     <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      nblk_q     <= nblk_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    nblk_d     = nblk_q;
    addr_d     = addr_q;
    word_d     = word_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nblk_d     = n_blocks;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          blk_cnt_d  = '0;
          word_d     = '0;
          if (n_blocks == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = first_addr;
            state_d = OPEN;
          end
        end
      end
      OPEN: if (hs_cmpl) state_d = BYTE;
      BYTE: begin
        if (hs_cmpl) begin
          word_d[{lane, 3'b000} +: 8] = core_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (word_full) state_d = PUSH;
        end
      end
      PUSH: begin
        if (out_tready) begin
          word_d  = '0;
          state_d = sector_end ? NEXT : BYTE;
        end
      end
      NEXT: begin
        blk_cnt_d  = blk_cnt_q + 1'b1;
        byte_cnt_d = '0;
        addr_d     = addr_q + 32'd1;
        state_d    = (blk_cnt_d == nblk_q) ? DONE : OPEN;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (err_evt) begin
      state_d = ERR;
      err_d   = 1'b1;
      word_d  = '0;
      done_d  = 1'b0;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign core_addr  = addr_q;
  // A word on offer is withdrawn in the cycle an error is seen.
  assign out_tvalid = (state_q == PUSH) && !err_evt;
  assign out_tdata  = word_q;
  assign out_tlast  = out_tvalid && sector_end;

endmodule
